// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - one requester's view of the shared RAM port arbiter
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic                  req;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  lock;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter for RAM port B; lock support under RAM_ARB_LOCK_EN
module ram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   m0,
  ram_port_arbiter_if.slave   m1,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_web,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_t;

  own_t             state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             gnt0, gnt1;
  logic             rv0_q, rv1_q;
  logic             lock0, lock1;

`ifdef RAM_ARB_LOCK_EN
  assign lock0 = m0.lock;
  assign lock1 = m1.lock;
`else
  logic unused_lock;
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
  assign unused_lock = m0.lock ^ m1.lock;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  // Grant selection, pointer rotation and ownership/lock-counter next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0.req && (!m1.req || !ptr_q)) gnt0 = 1'b1;
        else if (m1.req)                   gnt1 = 1'b1;
        // A lock only means something if the owner can get more than one grant
        if (gnt0 && lock0 && (MAX_LOCK > 1)) begin
          state_d = OWN0;
          cnt_d   = CNT_W'(1);
        end else if (gnt1 && lock1 && (MAX_LOCK > 1)) begin
          state_d = OWN1;
          cnt_d   = CNT_W'(1);
        end
      end
      OWN0: begin
        gnt0 = m0.req;
        if (!m0.req || !lock0 || (cnt_inc >= CNT_MAX)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      OWN1: begin
        gnt1 = m1.req;
        if (!m1.req || !lock1 || (cnt_inc >= CNT_MAX)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Grants are combinational, so they must be suppressed while reset is held
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    // Every grant hands priority to the other side, including a forced release
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  // Arbiter state and per-requester response-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rv0_q   <= gnt0;
      rv1_q   <= gnt1;
    end
  end

  // Steer the winner onto the RAM port; quiet port when nobody is granted
  always_comb begin
    ram_en   = gnt0 | gnt1;
    ram_web  = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_web  = m0.we;
      ram_addr = m0.addr;
      ram_din  = m0.wdata;
    end else if (gnt1) begin
      ram_web  = m1.we;
      ram_addr = m1.addr;
      ram_din  = m1.wdata;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rv0_q;
  assign m1.rvalid = rv1_q;
  // RAM output is the pre-write word, so writes return the old data too
  assign m0.rdata  = rv0_q ? ram_dout : '0;
  assign m1.rdata  = rv1_q ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized and directed bench for ram_port_arbiter against a behavioural model
module tb_ram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int ML = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_en;
  logic [BW-1:0] ram_web;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_if),
    .m1       (m1_if),
    .ram_en   (ram_en),
    .ram_web  (ram_web),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // RAM device: registered read-before-write with byte enables
  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < BW; b++)
        if (ram_web[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: owner (-1 none), streak length, priority side, pending responses
  int            own = -1;
  int            streak = 0;
  bit            ptr = 1'b0;
  bit            pend0 = 1'b0, pend1 = 1'b0;
  logic [DW-1:0] pd0 = '0, pd1 = '0;
  bit            g0_s = 1'b0, g1_s = 1'b0;
  bit            e0, e1, r_own, l_own;

  always @(negedge clk) begin
    if (!rst_n) begin
      own = -1; streak = 0; ptr = 1'b0; pend0 = 1'b0; pend1 = 1'b0; g0_s = 1'b0; g1_s = 1'b0;
      chk("rst_gnt",    {m0_if.gnt, m1_if.gnt}, 64'd0);
      chk("rst_rvalid", {m0_if.rvalid, m1_if.rvalid}, 64'd0);
      chk("rst_rdata0", m0_if.rdata, 64'd0);
      chk("rst_rdata1", m1_if.rdata, 64'd0);
      chk("rst_ram",    {ram_en, ram_web}, 64'd0);
    end else begin
      if (own == 0)      begin e0 = m0_if.req; e1 = 1'b0; end
      else if (own == 1) begin e0 = 1'b0; e1 = m1_if.req; end
      else if (m0_if.req && m1_if.req) begin e0 = (ptr == 1'b0); e1 = !e0; end
      else begin e0 = m0_if.req; e1 = m1_if.req; end

      chk("gnt0", m0_if.gnt, e0);
      chk("gnt1", m1_if.gnt, e1);
      chk("ram_en", ram_en, e0 | e1);
      if (e0)      chk("ram_port_m0", {ram_web, ram_addr, ram_din}, {m0_if.we, m0_if.addr, m0_if.wdata});
      else if (e1) chk("ram_port_m1", {ram_web, ram_addr, ram_din}, {m1_if.we, m1_if.addr, m1_if.wdata});
      else         chk("ram_web_idle", ram_web, 64'd0);
      chk("rvalid0", m0_if.rvalid, pend0);
      chk("rvalid1", m1_if.rvalid, pend1);
      chk("rdata0", m0_if.rdata, pend0 ? pd0 : '0);
      chk("rdata1", m1_if.rdata, pend1 ? pd1 : '0);

      if (e0) begin
        pd0 = ref_mem[m0_if.addr];
        for (int b = 0; b < BW; b++)
          if (m0_if.we[b]) ref_mem[m0_if.addr][b*8 +: 8] = m0_if.wdata[b*8 +: 8];
      end
      if (e1) begin
        pd1 = ref_mem[m1_if.addr];
        for (int b = 0; b < BW; b++)
          if (m1_if.we[b]) ref_mem[m1_if.addr][b*8 +: 8] = m1_if.wdata[b*8 +: 8];
      end
      pend0 = e0;
      pend1 = e1;
      if (e0)      ptr = 1'b1;
      else if (e1) ptr = 1'b0;
`ifdef RAM_ARB_LOCK_EN
      if (own < 0) begin
        if (e0 && m0_if.lock && ML > 1)      begin own = 0; streak = 1; end
        else if (e1 && m1_if.lock && ML > 1) begin own = 1; streak = 1; end
      end else begin
        r_own = (own == 0) ? m0_if.req  : m1_if.req;
        l_own = (own == 0) ? m0_if.lock : m1_if.lock;
        if (!r_own) begin
          own = -1; streak = 0;
        end else begin
          streak++;
          if (!l_own || streak >= ML) begin own = -1; streak = 0; end
        end
      end
`endif
      g0_s = m0_if.gnt;
      g1_s = m1_if.gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.req = 1'b0; m0_if.we = '0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.lock = 1'b0;
    m1_if.req = 1'b0; m1_if.we = '0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.lock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] k_dead;
  logic [DW-1:0] k_wr;
  logic [DW-1:0] k_merged;
  bit            exp_g0;

  initial begin
    k_dead   = 64'hDEADBEEF_00000001;
    k_wr     = 64'h11223344_55667788;
    k_merged = 64'h00000000_55667788;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[14'h0010]     = k_dead;
    ref_mem[14'h0010] = k_dead;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single m0 read, response one cycle later
    m0_if.req = 1'b1; m0_if.addr = 14'h0010;
    mid();
    chk("t029_gnt0", m0_if.gnt, 64'd1);
    chk("t029_gnt1", m1_if.gnt, 64'd0);
    chk("t029_addr", ram_addr, 64'h10);
    step();
    m0_if.req = 1'b0;
    mid();
    chk("t029_rvalid0", m0_if.rvalid, 64'd1);
    chk("t029_rdata0", m0_if.rdata, k_dead);
    chk("t029_m1_idle", {m1_if.gnt, m1_if.rvalid, m1_if.rdata}, 64'd0);

    // m1 partial write then back-to-back read of the same word
    step();
    m1_if.req = 1'b1; m1_if.we = 8'h0F; m1_if.addr = 14'h0020; m1_if.wdata = k_wr;
    mid();
    chk("t031_wr_gnt", m1_if.gnt, 64'd1);
    step();
    m1_if.we = '0;
    mid();
    chk("t031_wr_rvalid", m1_if.rvalid, 64'd1);
    chk("t031_wr_rdata", m1_if.rdata, 64'd0);
    chk("t031_rd_gnt", m1_if.gnt, 64'd1);
    step();
    m1_if.req = 1'b0;
    mid();
    chk("t031_rd_rvalid", m1_if.rvalid, 64'd1);
    chk("t031_rd_rdata", m1_if.rdata, k_merged);

    // Both requesting from reset: strict alternation
    step();
    idle_inputs();
    do_reset();
    m0_if.req = 1'b1; m0_if.addr = 14'h0003;
    m1_if.req = 1'b1; m1_if.addr = 14'h0004;
    for (int i = 0; i < 6; i++) begin
      mid();
      exp_g0 = (i % 2 == 0);
      chk($sformatf("t030_gnt0_c%0d", i), m0_if.gnt, exp_g0);
      chk($sformatf("t030_gnt1_c%0d", i), m1_if.gnt, !exp_g0);
      step();
    end
    idle_inputs();

    // m0 holds lock while m1 waits
    do_reset();
    m0_if.req = 1'b1; m0_if.lock = 1'b1; m0_if.addr = 14'h0005;
    m1_if.req = 1'b1; m1_if.addr = 14'h0006;
    for (int i = 0; i < 5; i++) begin
      mid();
`ifdef RAM_ARB_LOCK_EN
      exp_g0 = (i < 4);
`else
      exp_g0 = (i % 2 == 0);
`endif
      chk($sformatf("t032_gnt0_c%0d", i), m0_if.gnt, exp_g0);
      chk($sformatf("t032_gnt1_c%0d", i), m1_if.gnt, !exp_g0);
      step();
    end
    idle_inputs();

    // Reset pulsed in the cycle after a grant drops the response
    step();
    m0_if.req = 1'b1; m0_if.addr = 14'h0010;
    mid();
    chk("t033_gnt0", m0_if.gnt, 64'd1);
    step();
    m0_if.req = 1'b0;
    rst_n = 1'b0;
    mid();
    chk("t033_rst_rvalid0", m0_if.rvalid, 64'd0);
    chk("t033_rst_ram_en", ram_en, 64'd0);
    step();
    rst_n = 1'b1;
    m0_if.req = 1'b1; m0_if.addr = 14'h0007;
    m1_if.req = 1'b1; m1_if.addr = 14'h0008;
    mid();
    chk("t033_post_rvalid0", m0_if.rvalid, 64'd0);
    chk("t033_ptr_restart", {m0_if.gnt, m1_if.gnt}, 64'b10);
    step();
    idle_inputs();

    // Randomized traffic, requests held until granted
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_n = ($urandom_range(0, 399) != 0);
      if (!m0_if.req || g0_s) begin
        m0_if.req   = ($urandom_range(0, 3) != 0);
        m0_if.we    = $urandom_range(0, 1) ? BW'($urandom) : '0;
        m0_if.addr  = AW'($urandom_range(0, 31));
        m0_if.wdata = {$urandom, $urandom};
      end
      if (!m1_if.req || g1_s) begin
        m1_if.req   = ($urandom_range(0, 3) != 0);
        m1_if.we    = $urandom_range(0, 1) ? BW'($urandom) : '0;
        m1_if.addr  = AW'($urandom_range(0, 31));
        m1_if.wdata = {$urandom, $urandom};
      end
      m0_if.lock = ($urandom_range(0, 3) != 0);
      m1_if.lock = ($urandom_range(0, 3) != 0);
    end
    step();
    idle_inputs();
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
